// File: rtl/kv_mem_port_arbiter.sv
// kv_mem_port_arbiter
// Shares one single-outstanding memory port between DATA_NUM requesters.
// A winner is picked from the request valids, its request is latched and
// driven to memory, and the memory response is steered back to that owner.
// Build option: define KV_ARB_ROUND_ROBIN_EN for a rotating-priority search
// starting at a pointer that moves past each winner; leave it undefined for
// fixed priority (lowest index wins, no pointer register).
module kv_mem_port_arbiter #(
  parameter int DATA_NUM   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_NUM-1:0]   i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr  [DATA_NUM-1:0],
  input  logic [DATA_WIDTH-1:0] i_req_wdata [DATA_NUM-1:0],
  input  logic [DATA_NUM-1:0]   i_req_we,
  output logic [DATA_NUM-1:0]   o_req_ready,
  output logic                  o_mem_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_NUM-1:0]   o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data
);

  localparam int IDX_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      owner_q;
  logic                  mem_valid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_we_q;
  logic [DATA_NUM-1:0]   rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;

`ifdef KV_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      rr_ptr_d;
  logic [IDX_W:0]        cand;

  // Rotating search: scan DATA_NUM candidates starting at the pointer, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < DATA_NUM; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(DATA_NUM)) begin
        cand = cand - (IDX_W+1)'(DATA_NUM);
      end
      if (!grant_found && i_req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the winner, wrapping at the top
  always_comb begin
    if (grant_idx == (IDX_W)'(DATA_NUM - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_idx + 1'b1;
    end
  end

  // Pointer only advances when a grant is actually issued from IDLE
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
    end else if (state_q == ST_IDLE && grant_found) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: the lowest-indexed valid requester wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < DATA_NUM; k++) begin
      if (!grant_found && i_req_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = (IDX_W)'(k);
      end
    end
  end
`endif

  // Accept is offered only while idle, one-hot to the current winner
  always_comb begin
    o_req_ready = '0;
    if (state_q == ST_IDLE && grant_found) begin
      o_req_ready[grant_idx] = 1'b1;
    end
  end

  // Transaction FSM: latch winner, present to memory, route the response back
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            owner_q     <= grant_idx;
            mem_addr_q  <= i_req_addr[grant_idx];
            mem_wdata_q <= i_req_wdata[grant_idx];
            mem_we_q    <= i_req_we[grant_idx];
            mem_valid_q <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_data_q           <= mem_we_q ? '0 : i_mem_rdata;
            state_q              <= ST_IDLE;
          end
        end
        default: begin
          mem_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mem_valid = mem_valid_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_we    = mem_we_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

endmodule
